prime_check: RTL
================

# prime_check

Trial-division primality tester. It is the initiating side of the `modulo` go/ready protocol: the block accepts a candidate `n`, issues a sequence of `n mod d` requests to an external `modulo` instance, and reports whether `n` is prime. It sits between the prime-generator sequencer and the shared `modulo` unit.

## Interface
- `WIDTH`, 16, width of `n`, the divisor and the `modulo` operands.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `go`  in  1  start request; rising-edge triggered (`go && !go_prev`).
- `n`  in  WIDTH  candidate; sampled on the accepted `go` edge only.
- `ready`  out  1  idle, with result valid.
- `error`  out  1  the last check aborted because `modulo` reported an error.
- `is_prime`  out  1  result of the last completed check.
- `mod_go`  out  1  request strobe to `modulo`; high for exactly one cycle per request.
- `mod_a`  out  WIDTH  dividend to `modulo`; always the latched `n`.
- `mod_b`  out  WIDTH  divisor `d` to `modulo`.
- `mod_ready`  in  1  `modulo` ready.
- `mod_error`  in  1  `modulo` error.
- `mod_res`  in  WIDTH  `modulo` remainder; valid when `mod_ready=1` and `mod_error=0`.

## Operation
- States: IDLE, INIT, CHECK, ISSUE, WAIT, ERROR.
- IDLE: `ready=1`. An accepted `go` edge latches `n` and moves to INIT.
  - A `go` edge seen in any other state is ignored.
  - `go_prev` updates every cycle, so holding `go` high starts exactly one check.
- INIT:
  - `n<2`: go to IDLE with `is_prime=0`.
  - Otherwise set `d=2`, `sq=4`, go to CHECK.
- CHECK:
  - `sq > n`: go to IDLE with `is_prime=1`.
  - Otherwise go to ISSUE.
- ISSUE: drive `mod_go=1`, `mod_a=n`, `mod_b=d`; go to WAIT.
- WAIT:
  - `mod_go=0`; `mod_a` and `mod_b` are held stable.
  - Stay in WAIT while `mod_ready=0`.
  - `mod_ready=1` and `mod_error=1`: go to ERROR.
  - `mod_ready=1` and `mod_res==0`: go to IDLE with `is_prime=0`.
  - Otherwise advance the divisor and go to CHECK.
- Divisor advance (full search): `sq <= sq + 2*d + 1`, then `d <= d + 1`. Both updates use the old `d`.
- ERROR: `ready=1`, `error=1`, `is_prime=0`. It behaves as IDLE for the next `go` edge.
- Any new accepted `go` clears `error`.
- Width rules:
  - `d` is WIDTH bits.
  - `sq` is 2*WIDTH bits, so it cannot overflow for any `n ≤ 2^WIDTH-1`.
  - Compare `sq > n` with `n` zero-extended.
- `is_prime` holds its value from the previous check until the next completion.

## Timing
- Reset values:
  - state IDLE, `ready=1`, `error=0`, `is_prime=0`.
  - `mod_go=0`, `mod_a=0`, `mod_b=0`, `go_prev=0`.
- All outputs are registered.
  - `ready` and `error` are computed from the next state, as in `modulo`.
  - `ready` therefore falls on the same edge that accepts `go`.
- `modulo` updates `mod_ready` on the edge that samples `mod_go`. The first WAIT cycle therefore already shows fresh status, and no stale `mod_ready=1` is possible.
- Latency from the accepted `go` edge to `ready=1`:
  - `n<2`: 2 cycles.
  - `n` in 2..3: 3 cycles.
  - Each `modulo` request adds 2 cycles (CHECK + ISSUE) plus the WAIT cycles.
- Reset mid-operation:
  - Returns to the reset state on the next edge.
  - `mod_go` drops immediately.
  - An outstanding `modulo` result is ignored; `modulo` itself is reset by the same `rst`.
- Since `d ≥ 2`, `mod_error` is never expected. It is handled only as a fault path.

## Configuration
- `PRIME_CHECK_ODD_ONLY_EN` defined:
  - After `d=2` returns a nonzero remainder, set `d=3`, `sq=9`.
  - After that, advance by `sq <= sq + 4*d + 4`, `d <= d + 2`.
  - Even divisors above 2 are never issued.
- Not defined: every `d` from 2 upward is issued.
- Results are identical with or without the macro; only the request count and latency differ.

## Test plan
- `n=0`, then `n=1` -> `is_prime=0`, `ready=1` two cycles after each `go` edge, no `mod_go` pulse.
- `n=2` -> `is_prime=1` after 3 cycles, zero requests. `n=9` -> requests `d=2`, `d=3`; `mod_res=0` at `d=3` gives `is_prime=0`.
- `n=97` -> `is_prime=1`, `error=0`.
  - Macro off: requests `d=2..9`, 8 `mod_go` pulses.
  - Macro on: `d=2,3,5,7,9`, 5 pulses.
- `n=65521` with WIDTH=16 -> `is_prime=1` with no `sq` overflow. `n=65535` -> `is_prime=0` at `d=3`.
- Model returns `mod_ready=1`, `mod_error=1` on the first request -> `ready=1`, `error=1`, `is_prime=0`. A following `go` with `n=5` clears `error` and gives `is_prime=1`.
- `go` held high for 50 cycles -> exactly one check.
- `go` edge during WAIT -> ignored.
- `rst` asserted during WAIT -> the next cycle shows `ready=1`, `error=0`, `is_prime=0`, `mod_go=0`.

Source files
------------

// File: rtl/prime_check.sv
// prime_check: trial-division primality tester driving an external modulo unit.
// Candidate n is latched on a go rising edge. The block then issues n mod d requests
// for d = 2, 3, ... while d*d <= n, and reports is_prime when the search ends.
// Optional build macro PRIME_CHECK_ODD_ONLY_EN: after d=2 only odd divisors are issued.
module prime_check #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             error,
    output logic             is_prime,
    output logic             mod_go,
    output logic [WIDTH-1:0] mod_a,
    output logic [WIDTH-1:0] mod_b,
    input  logic             mod_ready,
    input  logic             mod_error,
    input  logic [WIDTH-1:0] mod_res
);

    typedef enum logic [2:0] {StIdle, StInit, StCheck, StIssue, StWait, StError} state_e;

    state_e               state_q, state_d;
    logic                 go_prev_q;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [2*WIDTH-1:0]   sq_q, sq_d;
    logic                 is_prime_d, ready_d, error_d, mod_go_d;
    logic [WIDTH-1:0]     mod_a_d, mod_b_d;

    logic                 go_edge, accept, sq_gt_n, n_small, res_back, advance;
    logic [2*WIDTH-1:0]   n_ext, d_ext;

    assign go_edge  = go && !go_prev_q;
    assign accept   = ((state_q == StIdle) || (state_q == StError)) && go_edge;
    assign n_ext    = {{WIDTH{1'b0}}, n_q};
    assign d_ext    = {{WIDTH{1'b0}}, d_q};
    // sq is twice as wide as n, so this compare cannot wrap for any candidate
    assign sq_gt_n  = sq_q > n_ext;
    assign n_small  = n_q < WIDTH'(2);
    assign res_back = (state_q == StWait) && mod_ready;
    assign advance  = res_back && !mod_error && (mod_res != '0);

    // State register plus registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            go_prev_q <= 1'b0;
            n_q       <= '0;
            d_q       <= '0;
            sq_q      <= '0;
            ready     <= 1'b1;
            error     <= 1'b0;
            is_prime  <= 1'b0;
            mod_go    <= 1'b0;
            mod_a     <= '0;
            mod_b     <= '0;
        end else begin
            state_q   <= state_d;
            go_prev_q <= go;
            n_q       <= n_d;
            d_q       <= d_d;
            sq_q      <= sq_d;
            ready     <= ready_d;
            error     <= error_d;
            is_prime  <= is_prime_d;
            mod_go    <= mod_go_d;
            mod_a     <= mod_a_d;
            mod_b     <= mod_b_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StError: if (go_edge) state_d = StInit;
            StInit:          state_d = n_small ? StIdle : StCheck;
            StCheck:         state_d = sq_gt_n ? StIdle : StIssue;
            StIssue:         state_d = StWait;
            StWait: begin
                if (mod_ready) begin
                    if (mod_error)            state_d = StError;
                    else if (mod_res == '0)   state_d = StIdle;
                    else                      state_d = StCheck;
                end
            end
            default:         state_d = StIdle;
        endcase
    end

    // Datapath and output next values; ready/error/mod_go follow the next state
    always_comb begin
        n_d        = accept ? n : n_q;
        d_d        = d_q;
        sq_d       = sq_q;
        is_prime_d = is_prime;

        if (state_q == StInit) begin
            d_d  = WIDTH'(2);
            sq_d = (2 * WIDTH)'(4);
            if (n_small) is_prime_d = 1'b0;
        end

        if ((state_q == StCheck) && sq_gt_n) is_prime_d = 1'b1;

        // Fault or zero remainder both end the check as not prime
        if (res_back && (mod_error || (mod_res == '0))) is_prime_d = 1'b0;

        // Both sq and d updates are based on the old d
        if (advance) begin
`ifdef PRIME_CHECK_ODD_ONLY_EN
            if (d_q == WIDTH'(2)) begin
                d_d  = WIDTH'(3);
                sq_d = (2 * WIDTH)'(9);
            end else begin
                sq_d = sq_q + (d_ext << 2) + (2 * WIDTH)'(4);
                d_d  = d_q + WIDTH'(2);
            end
`else
            sq_d = sq_q + (d_ext << 1) + (2 * WIDTH)'(1);
            d_d  = d_q + WIDTH'(1);
`endif
        end

        ready_d  = (state_d == StIdle) || (state_d == StError);
        error_d  = (state_d == StError);
        mod_go_d = (state_d == StIssue);
        mod_a_d  = mod_a;
        mod_b_d  = mod_b;
        if (state_d == StIssue) begin
            mod_a_d = n_q;
            mod_b_d = d_q;
        end
    end

endmodule
